matrix_multiply_engine: RTL and testbench

Parametrised fixed-point matrix multiplier with three internal banks (X, Y, Z), runtime-programmable dimensions, an optional accumulate mode (Z += X·Y) and saturating writeback. The host loads X and Y through a shared word port, pulses `start`, waits for `done`, then reads Z through the same port. It is the general-purpose compute block for reservoir/readout matrix products in the DFR datapath.

---
 rtl/matrix_multiply_engine.sv | 167 ++++++++++++++++
 tb/tb_matrix_multiply_engine.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/matrix_multiply_engine.sv
// matrix_multiply_engine: fixed-point Z = X*Y (or Z += X*Y) over three host-loadable banks
module matrix_multiply_engine #(
    parameter int DATA_WIDTH     = 32,
    parameter int FRAC_BITS      = 16,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int DIM_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIM_WIDTH-1:0]      x_rows,
    input  logic [DIM_WIDTH-1:0]      inner,
    input  logic [DIM_WIDTH-1:0]      y_cols,
    input  logic                      accumulate,
    input  logic [1:0]                ram_sel,
    input  logic [MEM_ADDR_WIDTH-1:0] ram_addr,
    input  logic                      ram_wen,
    input  logic [DATA_WIDTH-1:0]     ram_data_in,
    output logic [DATA_WIDTH-1:0]     ram_data_out,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;
    localparam int AW    = 2 * DATA_WIDTH + 8;

    typedef enum logic [2:0] {S_IDLE, S_ZLOAD, S_MAC, S_DRAIN, S_WRITE, S_FIN} state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] x_mem [DEPTH];
    logic [DATA_WIDTH-1:0] y_mem [DEPTH];
    logic [DATA_WIDTH-1:0] z_mem [DEPTH];

    logic signed [DATA_WIDTH-1:0]   x_rd, y_rd, z_rd;
    logic signed [2*DATA_WIDTH-1:0] prod_full, prod;
    logic signed [AW-1:0]           acc;
    logic [DATA_WIDTH-1:0]          z_sat;
    logic [DIM_WIDTH-1:0]           m_r, k_r, n_r, i_cnt, j_cnt, k_cnt;
    logic [MEM_ADDR_WIDTH-1:0]      x_row, x_ptr, y_ptr, z_ptr;
    logic                           acc_mode, drain_cnt, rd_v, prod_v;
    logic [31:0]                    mk, kn, mn;
    logic                           dims_ok, accept, last_k, last_elem;

    assign mk        = 32'(x_rows) * 32'(inner);
    assign kn        = 32'(inner) * 32'(y_cols);
    assign mn        = 32'(x_rows) * 32'(y_cols);
    assign dims_ok   = (x_rows != '0) && (inner != '0) && (y_cols != '0) &&
                       (mk <= 32'(DEPTH)) && (kn <= 32'(DEPTH)) && (mn <= 32'(DEPTH));
    assign accept    = (state == S_IDLE) && start && dims_ok;
    assign last_k    = k_cnt == k_r - 1'b1;
    assign last_elem = (i_cnt == m_r - 1'b1) && (j_cnt == n_r - 1'b1);
    assign prod_full = (2*DATA_WIDTH)'(x_rd) * (2*DATA_WIDTH)'(y_rd);
    // Result fits when every bit above the sign position agrees with the sign
    assign z_sat     = (&acc[AW-1:DATA_WIDTH-1] || ~|acc[AW-1:DATA_WIDTH-1]) ? acc[DATA_WIDTH-1:0] :
                       acc[AW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state: optional Z seed load, K MAC issues, 2-cycle pipeline flush, writeback
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = accept ? (accumulate ? S_ZLOAD : S_MAC) : S_IDLE;
            S_ZLOAD: state_nxt = S_MAC;
            S_MAC:   state_nxt = last_k ? S_DRAIN : S_MAC;
            S_DRAIN: state_nxt = drain_cnt ? S_WRITE : S_DRAIN;
            S_WRITE: state_nxt = last_elem ? S_FIN : (acc_mode ? S_ZLOAD : S_MAC);
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = state inside {S_ZLOAD, S_MAC, S_DRAIN, S_WRITE};
        done = state == S_FIN;
    end

    // Datapath: walking pointers (Z is sequential in i-outer/j-inner order), multiply pipe, accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error     <= 1'b0;
            m_r       <= '0;
            k_r       <= '0;
            n_r       <= '0;
            acc_mode  <= 1'b0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            x_row     <= '0;
            x_ptr     <= '0;
            y_ptr     <= '0;
            z_ptr     <= '0;
            drain_cnt <= 1'b0;
            rd_v      <= 1'b0;
            prod_v    <= 1'b0;
            prod      <= '0;
            acc       <= '0;
        end else begin
            rd_v      <= state == S_MAC;
            prod_v    <= rd_v;
            prod      <= prod_full >>> FRAC_BITS;
            drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
            if (state == S_IDLE && start) error <= !dims_ok;
            if (accept) begin
                m_r      <= x_rows;
                k_r      <= inner;
                n_r      <= y_cols;
                acc_mode <= accumulate;
                i_cnt    <= '0;
                j_cnt    <= '0;
                k_cnt    <= '0;
                x_row    <= '0;
                x_ptr    <= '0;
                y_ptr    <= '0;
                z_ptr    <= '0;
            end
            if (state == S_MAC) begin
                x_ptr <= x_ptr + 1'b1;
                y_ptr <= y_ptr + MEM_ADDR_WIDTH'(n_r);
                k_cnt <= k_cnt + 1'b1;
            end
            if (state == S_MAC && k_cnt == '0) acc <= acc_mode ? AW'(z_rd) : '0;
            else if (prod_v)                   acc <= acc + AW'(prod);
            if (state == S_WRITE) begin
                z_ptr <= z_ptr + 1'b1;
                k_cnt <= '0;
                if (j_cnt == n_r - 1'b1) begin
                    j_cnt <= '0;
                    i_cnt <= i_cnt + 1'b1;
                    x_row <= x_row + MEM_ADDR_WIDTH'(k_r);
                    x_ptr <= x_row + MEM_ADDR_WIDTH'(k_r);
                    y_ptr <= '0;
                end else begin
                    j_cnt <= j_cnt + 1'b1;
                    x_ptr <= x_row;
                    y_ptr <= MEM_ADDR_WIDTH'(j_cnt) + 1'b1;
                end
            end
        end
    end

    // Banks: engine read ports, host writes when idle, engine writeback into Z
    always_ff @(posedge clk) begin
        x_rd <= x_mem[x_ptr];
        y_rd <= y_mem[y_ptr];
        z_rd <= z_mem[z_ptr];
        if (ram_wen && !busy && ram_sel == 2'd0) x_mem[ram_addr] <= ram_data_in;
        if (ram_wen && !busy && ram_sel == 2'd1) y_mem[ram_addr] <= ram_data_in;
        if (state == S_WRITE)                         z_mem[z_ptr]    <= z_sat;
        else if (ram_wen && !busy && ram_sel == 2'd2) z_mem[ram_addr] <= ram_data_in;
    end

    // Registered host read, blanked while computing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ram_data_out <= '0;
        else      ram_data_out <= busy ? '0 :
                                  ram_sel == 2'd0 ? x_mem[ram_addr] :
                                  ram_sel == 2'd1 ? y_mem[ram_addr] :
                                  ram_sel == 2'd2 ? z_mem[ram_addr] : '0;
    end
endmodule

// File: tb/tb_matrix_multiply_engine.sv
// tb_matrix_multiply_engine: directed runs checked against a whole-matrix reference model
module tb_matrix_multiply_engine;
    logic        clk = 0, rst = 0, start = 0, accumulate = 0, ram_wen = 0;
    logic [7:0]  x_rows = 0, inner = 0, y_cols = 0, ram_addr = 0;
    logic [1:0]  ram_sel = 2'd3;
    logic [31:0] ram_data_in = 0;
    logic [31:0] ram_data_out;
    logic        busy, done, error;
    int total = 0, bad = 0;

    matrix_multiply_engine #(.DATA_WIDTH(32), .FRAC_BITS(16), .MEM_ADDR_WIDTH(8), .DIM_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .x_rows(x_rows), .inner(inner), .y_cols(y_cols),
        .accumulate(accumulate), .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_wen(ram_wen),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: banks, busy countdown, and whole-matrix result computed at acceptance
    logic [31:0] mx [256], my [256], mz [256];
    bit          wx [256], wy [256], wz [256];
    int          busy_left = 0;
    bit          exp_done = 0, exp_err = 0, exp_known = 1, idle = 1;
    logic [31:0] exp_rd = 0;

    function automatic logic [31:0] sat(input longint s);
        return s > 64'sd2147483647 ? 32'h7FFFFFFF : s < -64'sd2147483648 ? 32'h80000000 : s[31:0];
    endfunction

    task automatic compute(input int m, input int k, input int n, input bit a);
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++) begin
                longint s;
                s = a ? longint'($signed(mz[i*n+j])) : 64'sd0;
                for (int q = 0; q < k; q++)
                    s += (longint'($signed(mx[i*k+q])) * longint'($signed(my[q*n+j]))) >>> 16;
                mz[i*n+j] = sat(s);
                wz[i*n+j] = 1;
            end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_left = 0; exp_done = 0; exp_err = 0; exp_rd = 0; exp_known = 1;
        end else begin
            idle = busy_left == 0 && !exp_done;
            exp_known = busy_left > 0 || ram_sel == 2'd3 ||
                        (ram_sel == 2'd0 ? wx[ram_addr] : ram_sel == 2'd1 ? wy[ram_addr] : wz[ram_addr]);
            exp_rd = busy_left > 0 ? 32'h0 : ram_sel == 2'd0 ? mx[ram_addr] :
                     ram_sel == 2'd1 ? my[ram_addr] : ram_sel == 2'd2 ? mz[ram_addr] : 32'h0;
            if (ram_wen && busy_left == 0) begin
                if (ram_sel == 2'd0) begin mx[ram_addr] = ram_data_in; wx[ram_addr] = 1; end
                if (ram_sel == 2'd1) begin my[ram_addr] = ram_data_in; wy[ram_addr] = 1; end
                if (ram_sel == 2'd2) begin mz[ram_addr] = ram_data_in; wz[ram_addr] = 1; end
            end
            exp_done = busy_left == 1;
            if (busy_left > 0) busy_left--;
            if (idle && start) begin
                int m, k, n;
                m = int'(x_rows); k = int'(inner); n = int'(y_cols);
                if (m == 0 || k == 0 || n == 0 || m*k > 256 || k*n > 256 || m*n > 256) exp_err = 1;
                else begin
                    exp_err = 0;
                    busy_left = m * n * (k + 3 + int'(accumulate));
                    compute(m, k, n, accumulate);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", busy, busy_left > 0);
        chk("done", done, exp_done);
        chk("error", error, exp_err);
        if (exp_known) chk("rdata", ram_data_out, exp_rd);
    end

    task automatic wr(input logic [1:0] s, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk); ram_sel = s; ram_addr = a; ram_data_in = d; ram_wen = 1;
        @(negedge clk); ram_wen = 0;
    endtask

    task automatic rd(input logic [1:0] s, input logic [7:0] a, input logic [31:0] e, input string nm);
        @(negedge clk); ram_sel = s; ram_addr = a; ram_wen = 0;
        @(negedge clk); chk(nm, ram_data_out, e);
    endtask

    task automatic run(input logic [7:0] m, input logic [7:0] k, input logic [7:0] n, input bit a,
                       input int es, input int wa, output int bcnt, output int dcnt);
        @(negedge clk); x_rows = m; inner = k; y_cols = n; accumulate = a; start = 1;
        @(negedge clk); start = 0; bcnt = 0; dcnt = 0;
        for (int c = 0; c < 2000; c++) begin
            if (busy) bcnt++;
            if (done) begin dcnt++; break; end
            start = c == es;
            ram_wen = c == wa;
            if (c == wa) begin ram_sel = 2'd0; ram_addr = 0; ram_data_in = 32'hDEAD; end
            @(negedge clk);
        end
        start = 0; ram_wen = 0;
        repeat (4) begin @(negedge clk); if (done) dcnt++; end
    endtask

    task automatic load_identity();
        wr(0, 0, 32'h00010000); wr(0, 1, 32'h00020000); wr(0, 2, 32'h00030000); wr(0, 3, 32'h00040000);
        wr(1, 0, 32'h00010000); wr(1, 1, 32'h0);        wr(1, 2, 32'h0);        wr(1, 3, 32'h00010000);
    endtask

    initial begin
        int b, d, cnt;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_error", error, 0); chk("rst_rdata", ram_data_out, 0);
        rst = 1;
        load_identity();
        run(2, 2, 2, 0, -1, -1, b, d);
        chk("id_busy_cycles", b, 20); chk("id_done_pulses", d, 1);
        rd(2, 0, 32'h00010000, "id_z00"); rd(2, 1, 32'h00020000, "id_z01");
        rd(2, 2, 32'h00030000, "id_z10"); rd(2, 3, 32'h00040000, "id_z11");
        run(2, 2, 2, 1, -1, -1, b, d);
        chk("acc_busy_cycles", b, 24); chk("acc_done_pulses", d, 1);
        rd(2, 0, 32'h00020000, "acc_z00"); rd(2, 1, 32'h00040000, "acc_z01");
        rd(2, 2, 32'h00060000, "acc_z10"); rd(2, 3, 32'h00080000, "acc_z11");
        for (int i = 0; i < 6; i++) wr(0, 8'(i), 32'(i + 1) << 16);
        for (int i = 0; i < 3; i++) wr(1, 8'(i), 32'h00010000);
        run(2, 3, 1, 0, -1, -1, b, d);
        chk("ns_busy_cycles", b, 12);
        rd(2, 0, 32'h00060000, "ns_z0"); rd(2, 1, 32'h000F0000, "ns_z1");
        wr(0, 0, 32'h7FFF0000); wr(1, 0, 32'h00020000);
        run(1, 1, 1, 0, -1, -1, b, d);
        chk("satp_busy_cycles", b, 4);
        rd(2, 0, 32'h7FFFFFFF, "sat_pos");
        wr(0, 0, 32'h80000000);
        run(1, 1, 1, 0, -1, -1, b, d);
        rd(2, 0, 32'h80000000, "sat_neg");
        @(negedge clk); x_rows = 0; inner = 2; y_cols = 2; accumulate = 0; start = 1;
        @(negedge clk); start = 0;
        chk("rej_error", error, 1);
        cnt = 0;
        repeat (6) begin @(negedge clk); if (busy || done) cnt++; end
        chk("rej_no_activity", cnt, 0);
        rd(2, 0, 32'h80000000, "rej_z0_kept"); rd(2, 1, 32'h000F0000, "rej_z1_kept");
        load_identity();
        run(2, 2, 2, 0, 3, 5, b, d);
        chk("ign_busy_cycles", b, 20); chk("ign_done_pulses", d, 1);
        chk("accept_clears_error", error, 0);
        rd(0, 0, 32'h00010000, "busy_write_dropped"); rd(2, 3, 32'h00040000, "ign_z11");
        @(negedge clk); x_rows = 17; inner = 16; y_cols = 1; start = 1;
        @(negedge clk); start = 0;
        chk("rej_depth_error", error, 1);
        @(negedge clk); x_rows = 2; inner = 2; y_cols = 2; accumulate = 0; start = 1;
        @(negedge clk); start = 0;
        repeat (4) @(negedge clk);
        @(posedge clk); #2 rst = 0;
        #1 chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
        chk("mid_rst_error", error, 0); chk("mid_rst_rdata", ram_data_out, 0);
        @(negedge clk); @(negedge clk); rst = 1;
        run(2, 2, 2, 0, -1, -1, b, d);
        chk("post_rst_busy_cycles", b, 20); chk("post_rst_done_pulses", d, 1);
        rd(2, 0, 32'h00010000, "post_rst_z00"); rd(2, 3, 32'h00040000, "post_rst_z11");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
